// File: rtl/field_op_dispatcher_if.sv
// Load-side and decoder-side signal bundle for field_op_dispatcher.
// slave = the dispatcher; master = the message loader together with the decoder pool.
interface field_op_dispatcher_if #(
    parameter int field_op_size    = 32,
    parameter int max_message_size = 10,
    parameter int num_decoders     = 4
);
    logic                                     load_valid;
    logic                                     load_ready;
    logic [field_op_size-1:0]                 load_ops [max_message_size];
    logic [$clog2(max_message_size+1)-1:0]    load_count;
    logic                                     abort;
    logic [num_decoders-1:0]                  dec_done;
    logic [num_decoders-1:0]                  dec_issue;
    logic [field_op_size-1:0]                 dec_op [num_decoders];
    logic [num_decoders-1:0]                  dec_busy;
    logic                                     message_done;
    logic                                     err_spurious;

    modport master (
        output load_valid, load_ops, load_count, abort, dec_done,
        input  load_ready, dec_issue, dec_op, dec_busy, message_done, err_spurious
    );

    modport slave (
        input  load_valid, load_ops, load_count, abort, dec_done,
        output load_ready, dec_issue, dec_op, dec_busy, message_done, err_spurious
    );
endinterface

// File: rtl/field_op_dispatcher.sv
// Hands a message's field ops, strictly in index order, to free decoder slots round-robin.
// Latency: first dec_issue one cycle after the load edge, then at most one op per cycle.
// Backpressure: load_ready only while idle; issue stalls while every slot is busy.
module field_op_dispatcher #(
    parameter int field_op_size    = 32,
    parameter int max_message_size = 10,
    parameter int num_decoders     = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    field_op_dispatcher_if.slave bus
);
    localparam int cnt_w = $clog2(max_message_size + 1);
    localparam int ptr_w = (num_decoders > 1) ? $clog2(num_decoders) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [cnt_w-1:0]         count_q, count_d;
    logic [cnt_w-1:0]         issued_q, issued_d;
    logic [cnt_w-1:0]         completed_q, completed_d;
    logic [ptr_w-1:0]         rr_ptr_q, rr_ptr_d;
    logic [num_decoders-1:0]  busy_q, busy_d;
    logic [num_decoders-1:0]  issue_q, issue_d;
    logic                     msg_done_q, msg_done_d;
    logic                     err_q, err_d;
    logic [field_op_size-1:0] ops_q [max_message_size];
    logic [field_op_size-1:0] op_q [num_decoders];

    logic                     load_fire;
    logic                     issue_fire;
    logic                     slot_found;
    logic [ptr_w-1:0]         slot_sel;
    logic [cnt_w-1:0]         load_count_clamped;
    logic [num_decoders-1:0]  done_valid;
    int                       done_total;

    assign load_fire          = bus.load_valid && (state_q == IDLE);
    assign done_valid         = bus.dec_done & busy_q;
    assign load_count_clamped = (int'(bus.load_count) > max_message_size) ?
                                cnt_w'(max_message_size) : bus.load_count;

    // Eligibility looks only at registered busy: a slot finishing this cycle waits one edge.
    always_comb begin
        slot_found = 1'b0;
        slot_sel   = '0;
        for (int k = 0; k < num_decoders; k++) begin
            if (!slot_found && !busy_q[(int'(rr_ptr_q) + k) % num_decoders]) begin
                slot_found = 1'b1;
                slot_sel   = ptr_w'((int'(rr_ptr_q) + k) % num_decoders);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        issued_d    = issued_q;
        completed_d = completed_q;
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q & ~done_valid;
        issue_d     = '0;
        issue_fire  = 1'b0;
        err_d       = err_q | (|(bus.dec_done & ~busy_q));
        done_total  = int'(completed_q) + $countones(done_valid);

        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    count_d     = load_count_clamped;
                    issued_d    = '0;
                    completed_d = '0;
                    state_d     = (load_count_clamped == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                completed_d = cnt_w'(done_total);
                if (slot_found) begin
                    issue_fire        = 1'b1;
                    issue_d[slot_sel] = 1'b1;
                    busy_d[slot_sel]  = 1'b1;
                    issued_d          = issued_q + 1'b1;
                    rr_ptr_d          = (int'(slot_sel) == num_decoders - 1) ? '0 : slot_sel + 1'b1;
                    if (issued_q + 1'b1 == count_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                completed_d = cnt_w'(done_total);
                if (done_total >= int'(count_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over any issue or completion decided above; rr_ptr is kept.
        if (bus.abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            count_d     = '0;
            issued_d    = '0;
            completed_d = '0;
            busy_d      = '0;
            issue_d     = '0;
            issue_fire  = 1'b0;
        end

        msg_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            count_q     <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            rr_ptr_q    <= '0;
            busy_q      <= '0;
            issue_q     <= '0;
            msg_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            issue_q     <= issue_d;
            msg_done_q  <= msg_done_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < max_message_size; k++) begin
                ops_q[k] <= '0;
            end
            for (int k = 0; k < num_decoders; k++) begin
                op_q[k] <= '0;
            end
        end else begin
            if (load_fire) begin
                for (int k = 0; k < max_message_size; k++) begin
                    ops_q[k] <= bus.load_ops[k];
                end
            end
            if (issue_fire) begin
                op_q[slot_sel] <= ops_q[issued_q];
            end
        end
    end

    assign bus.load_ready   = (state_q == IDLE);
    assign bus.dec_issue    = issue_q;
    assign bus.dec_busy     = busy_q;
    assign bus.message_done = msg_done_q;
    assign bus.err_spurious = err_q;

    for (genvar g = 0; g < num_decoders; g++) begin : g_dec_op
        assign bus.dec_op[g] = op_q[g];
    end
endmodule

// File: tb/tb_field_op_dispatcher.sv
// Self-checking bench for field_op_dispatcher: issue scoreboard plus per-scenario tasks.
module tb_field_op_dispatcher;
    localparam int W  = 32;
    localparam int M  = 10;
    localparam int N  = 4;
    localparam int CW = $clog2(M + 1);

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    field_op_dispatcher_if #(.field_op_size(W), .max_message_size(M), .num_decoders(N)) bus ();

    field_op_dispatcher #(.field_op_size(W), .max_message_size(M), .num_decoders(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [W-1:0] exp_op_q [$];
    int exp_slot_q [$];
    int issue_cnt = 0;
    int md_cnt = 0;
    int md_cyc = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    bit auto_done = 1'b0;
    int tmr [N];

    always @(posedge clk) cyc++;

    // Scoreboard: every issue pops the next expected op (and slot when one was queued).
    always @(negedge clk) begin : monitor
        logic [W-1:0] e_op;
        int e_slot;
        if (rstn) begin
            for (int i = 0; i < N; i++) begin
                if (bus.dec_issue[i]) begin
                    issue_cnt++;
                    total_cnt++;
                    if (exp_op_q.size() == 0) begin
                        $display("FAIL issue_unexpected slot=%0d got_op=%h expected_no_issue", i, bus.dec_op[i]);
                    end else begin
                        e_op = exp_op_q.pop_front();
                        if (bus.dec_op[i] !== e_op)
                            $display("FAIL issue_op slot=%0d got=%h exp=%h", i, bus.dec_op[i], e_op);
                        else
                            pass_cnt++;
                    end
                    if (exp_slot_q.size() > 0) begin
                        e_slot = exp_slot_q.pop_front();
                        total_cnt++;
                        if (i != e_slot)
                            $display("FAIL issue_slot got=%0d exp=%0d", i, e_slot);
                        else
                            pass_cnt++;
                    end
                end
            end
            if (bus.message_done) begin
                md_cnt++;
                md_cyc = cyc;
            end
        end
    end

    // Automatic decoder model: each slot finishes three edges after its issue edge.
    always @(negedge clk) begin : responder
        logic [N-1:0] d;
        if (auto_done) begin
            d = '0;
            for (int i = 0; i < N; i++) begin
                if (bus.dec_issue[i]) begin
                    tmr[i] = 2;
                end else if (tmr[i] > 0) begin
                    tmr[i]--;
                    if (tmr[i] == 0) d[i] = 1'b1;
                end
            end
            bus.dec_done = d;
            if (d != '0) last_done_cyc = cyc;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic drive_load(input int cnt, input logic [W-1:0] base, input bit with_abort);
        bus.load_valid = 1'b1;
        bus.load_count = CW'(cnt);
        bus.abort      = with_abort;
        for (int i = 0; i < M; i++) bus.load_ops[i] = base + W'(i);
        step();
        bus.load_valid = 1'b0;
        bus.abort      = 1'b0;
    endtask

    task automatic wait_md(input int start, input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            step();
            if (md_cnt != start) seen = 1'b1;
        end
    endtask

    task automatic start_auto();
        for (int i = 0; i < N; i++) tmr[i] = 0;
        auto_done = 1'b1;
    endtask

    task automatic stop_auto();
        auto_done = 1'b0;
        bus.dec_done = '0;
    endtask

    task automatic test_reset();
        total_cnt++;
        if (bus.load_ready !== 1'b1) $display("FAIL reset_load_ready got=%b exp=1", bus.load_ready); else pass_cnt++;
        total_cnt++;
        if (bus.dec_busy !== 4'b0000) $display("FAIL reset_busy got=%b exp=0000", bus.dec_busy); else pass_cnt++;
        total_cnt++;
        if (bus.dec_issue !== 4'b0000) $display("FAIL reset_issue got=%b exp=0000", bus.dec_issue); else pass_cnt++;
        total_cnt++;
        if (bus.message_done !== 1'b0) $display("FAIL reset_msg_done got=%b exp=0", bus.message_done); else pass_cnt++;
        total_cnt++;
        if (bus.err_spurious !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.err_spurious); else pass_cnt++;
        total_cnt++;
        if (bus.dec_op[0] !== 32'h0 || bus.dec_op[3] !== 32'h0)
            $display("FAIL reset_dec_op got=%h,%h exp=0,0", bus.dec_op[0], bus.dec_op[3]);
        else pass_cnt++;
        rstn = 1'b1;
        step();
    endtask

    task automatic test_three_ops();
        int md0;
        bit seen;
        for (int i = 0; i < 3; i++) begin
            exp_op_q.push_back(32'hA + W'(i));
            exp_slot_q.push_back(i);
        end
        drive_load(3, 32'hA, 1'b0);
        total_cnt++;
        if (bus.dec_issue !== 4'b0000 || bus.load_ready !== 1'b0)
            $display("FAIL three_after_load issue=%b ready=%b exp=0000,0", bus.dec_issue, bus.load_ready);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (bus.dec_issue !== (4'b0001 << i))
                $display("FAIL three_issue_%0d got=%b exp=%b", i, bus.dec_issue, 4'b0001 << i);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if (bus.dec_issue !== 4'b0000 || bus.dec_busy !== 4'b0111 || bus.load_ready !== 1'b0)
            $display("FAIL three_drain issue=%b busy=%b ready=%b exp=0000,0111,0",
                     bus.dec_issue, bus.dec_busy, bus.load_ready);
        else pass_cnt++;
        md0 = md_cnt;
        bus.dec_done = 4'b0111;
        step();
        bus.dec_done = 4'b0000;
        wait_md(md0, 10, seen);
        total_cnt++;
        if (!seen) $display("FAIL three_msg_done got=timeout exp=pulse"); else pass_cnt++;
    endtask

    task automatic test_six_ops();
        int md0, iss0;
        bit seen;
        int slots [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            exp_op_q.push_back(32'h60 + W'(i));
            exp_slot_q.push_back(slots[i]);
        end
        md0 = md_cnt;
        iss0 = issue_cnt;
        start_auto();
        drive_load(6, 32'h60, 1'b0);
        wait_md(md0, 50, seen);
        total_cnt++;
        if (!seen) $display("FAIL six_msg_done got=timeout exp=pulse"); else pass_cnt++;
        total_cnt++;
        if (md_cyc != last_done_cyc + 1)
            $display("FAIL six_done_latency got_cycle=%0d exp_cycle=%0d", md_cyc, last_done_cyc + 1);
        else pass_cnt++;
        total_cnt++;
        if (issue_cnt - iss0 != 6 || exp_slot_q.size() != 0)
            $display("FAIL six_issue_count got=%0d exp=6 (slots left %0d)", issue_cnt - iss0, exp_slot_q.size());
        else pass_cnt++;
        for (int k = 0; k < 3; k++) step();
        total_cnt++;
        if (md_cnt != md0 + 1) $display("FAIL six_single_pulse got=%0d exp=1", md_cnt - md0); else pass_cnt++;
        stop_auto();
    endtask

    task automatic test_zero_count();
        int md0, iss0;
        md0 = md_cnt;
        iss0 = issue_cnt;
        drive_load(0, 32'h0, 1'b0);
        total_cnt++;
        if (bus.message_done !== 1'b1 || bus.dec_issue !== 4'b0000)
            $display("FAIL zero_done md=%b issue=%b exp=1,0000", bus.message_done, bus.dec_issue);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.message_done !== 1'b0 || bus.load_ready !== 1'b1)
            $display("FAIL zero_back_idle md=%b ready=%b exp=0,1", bus.message_done, bus.load_ready);
        else pass_cnt++;
        total_cnt++;
        if (md_cnt != md0 + 1 || issue_cnt != iss0)
            $display("FAIL zero_counts md=%0d issues=%0d exp=1,0", md_cnt - md0, issue_cnt - iss0);
        else pass_cnt++;
    endtask

    task automatic test_oversize();
        int md0, iss0;
        bit seen;
        for (int i = 0; i < M; i++) exp_op_q.push_back(32'h100 + W'(i));
        md0 = md_cnt;
        iss0 = issue_cnt;
        start_auto();
        drive_load(15, 32'h100, 1'b0);
        wait_md(md0, 100, seen);
        total_cnt++;
        if (!seen) $display("FAIL over_msg_done got=timeout exp=pulse"); else pass_cnt++;
        total_cnt++;
        if (issue_cnt - iss0 != M || exp_op_q.size() != 0)
            $display("FAIL over_issue_count got=%0d exp=%0d", issue_cnt - iss0, M);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (md_cnt != md0 + 1) $display("FAIL over_single_pulse got=%0d exp=1", md_cnt - md0); else pass_cnt++;
        stop_auto();
    endtask

    task automatic test_abort();
        int md0;
        bit seen;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_op_q.push_back(32'h30 + W'(i));
            exp_slot_q.push_back(i);
        end
        drive_load(3, 32'h30, 1'b0);
        for (int k = 0; k < 4; k++) step();
        bus.dec_done = 4'b0001;
        step();
        bus.dec_done = 4'b0000;
        total_cnt++;
        if (bus.dec_busy !== 4'b0110) $display("FAIL abort_pre_busy got=%b exp=0110", bus.dec_busy); else pass_cnt++;
        md0 = md_cnt;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        total_cnt++;
        if (bus.dec_busy !== 4'b0000 || bus.load_ready !== 1'b1 || bus.dec_issue !== 4'b0000 || bus.message_done !== 1'b0)
            $display("FAIL abort_state busy=%b ready=%b issue=%b md=%b exp=0000,1,0000,0",
                     bus.dec_busy, bus.load_ready, bus.dec_issue, bus.message_done);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (md_cnt != md0) $display("FAIL abort_no_done got=%0d exp=0", md_cnt - md0); else pass_cnt++;
        // Load offered together with abort while idle; rr_ptr continues from slot 3.
        exp_op_q.push_back(32'h40);
        exp_op_q.push_back(32'h41);
        exp_slot_q.push_back(3);
        exp_slot_q.push_back(0);
        drive_load(2, 32'h40, 1'b1);
        step();
        step();
        step();
        total_cnt++;
        if (bus.dec_busy !== 4'b1001) $display("FAIL abort_reload_busy got=%b exp=1001", bus.dec_busy); else pass_cnt++;
        bus.dec_done = 4'b1001;
        step();
        bus.dec_done = 4'b0000;
        wait_md(md0, 10, seen);
        total_cnt++;
        if (!seen) $display("FAIL abort_reload_done got=timeout exp=pulse"); else pass_cnt++;
    endtask

    task automatic test_spurious();
        int md0;
        bit seen;
        total_cnt++;
        if (bus.err_spurious !== 1'b0) $display("FAIL spur_pre got=%b exp=0", bus.err_spurious); else pass_cnt++;
        bus.dec_done = 4'b1000;
        step();
        bus.dec_done = 4'b0000;
        total_cnt++;
        if (bus.err_spurious !== 1'b1) $display("FAIL spur_set got=%b exp=1", bus.err_spurious); else pass_cnt++;
        exp_op_q.push_back(32'h50);
        exp_op_q.push_back(32'h51);
        exp_slot_q.push_back(1);
        exp_slot_q.push_back(2);
        drive_load(2, 32'h50, 1'b0);
        step();
        step();
        step();
        total_cnt++;
        if (bus.dec_busy !== 4'b0110) $display("FAIL spur_busy got=%b exp=0110", bus.dec_busy); else pass_cnt++;
        md0 = md_cnt;
        bus.dec_done = 4'b1010;
        step();
        bus.dec_done = 4'b0000;
        step();
        step();
        total_cnt++;
        if (md_cnt != md0 || bus.dec_busy !== 4'b0100)
            $display("FAIL spur_not_counted md=%0d busy=%b exp=0,0100", md_cnt - md0, bus.dec_busy);
        else pass_cnt++;
        bus.dec_done = 4'b0100;
        step();
        bus.dec_done = 4'b0000;
        wait_md(md0, 10, seen);
        total_cnt++;
        if (!seen || bus.err_spurious !== 1'b1)
            $display("FAIL spur_done_held seen=%b err=%b exp=1,1", seen, bus.err_spurious);
        else pass_cnt++;
        rstn = 1'b0;
        #1;
        total_cnt++;
        if (bus.err_spurious !== 1'b0) $display("FAIL spur_cleared got=%b exp=0", bus.err_spurious); else pass_cnt++;
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        int md0;
        bit seen;
        exp_op_q.push_back(32'h70);
        exp_slot_q.push_back(0);
        drive_load(3, 32'h70, 1'b0);
        step();
        rstn = 1'b0;
        #1;
        total_cnt++;
        if (bus.load_ready !== 1'b1 || bus.dec_busy !== 4'b0000 || bus.dec_issue !== 4'b0000)
            $display("FAIL midrst_async ready=%b busy=%b issue=%b exp=1,0000,0000",
                     bus.load_ready, bus.dec_busy, bus.dec_issue);
        else pass_cnt++;
        exp_op_q.delete();
        exp_slot_q.delete();
        step();
        rstn = 1'b1;
        step();
        step();
        total_cnt++;
        if (bus.dec_issue !== 4'b0000 || bus.load_ready !== 1'b1)
            $display("FAIL midrst_idle issue=%b ready=%b exp=0000,1", bus.dec_issue, bus.load_ready);
        else pass_cnt++;
        exp_op_q.push_back(32'h80);
        exp_slot_q.push_back(0);
        md0 = md_cnt;
        drive_load(1, 32'h80, 1'b0);
        step();
        total_cnt++;
        if (bus.dec_issue !== 4'b0001) $display("FAIL midrst_reissue got=%b exp=0001", bus.dec_issue); else pass_cnt++;
        bus.dec_done = 4'b0001;
        step();
        bus.dec_done = 4'b0000;
        wait_md(md0, 10, seen);
        total_cnt++;
        if (!seen) $display("FAIL midrst_done got=timeout exp=pulse"); else pass_cnt++;
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_count = '0;
        bus.abort      = 1'b0;
        bus.dec_done   = '0;
        for (int i = 0; i < M; i++) bus.load_ops[i] = '0;
        for (int i = 0; i < N; i++) tmr[i] = 0;
        step();
        step();
        test_reset();
        test_three_ops();
        test_six_ops();
        test_zero_count();
        test_oversize();
        test_abort();
        test_spurious();
        test_reset_mid();
        total_cnt++;
        if (exp_op_q.size() != 0) $display("FAIL leftover_ops got=%0d exp=0", exp_op_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/field_op_dispatcher.md
FIELD_OP_DISPATCHER -- requirements
Module: field_op_dispatcher

Interface
REQ-001 Parameter field_op_size, 32, width of one field op word.
REQ-002 Parameter max_message_size, 10, max fields per template message.
REQ-003 Parameter num_decoders, 4, number of field decoder slots served.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 load_valid  input  1  new message op list offered.
REQ-007 load_ready  output  1  dispatcher idle, can accept a load.
REQ-008 load_ops  input  field_op_size x max_message_size (unpacked array)  op per field, index 0 first.
REQ-009 load_count  input  $clog2(max_message_size+1)  number of valid fields in load_ops.
REQ-010 abort  input  1  discard current message.
REQ-011 dec_done  input  num_decoders  one-cycle pulse per slot: decoder finished its op.
REQ-012 dec_issue  output  num_decoders  one-cycle pulse per slot: new op presented.
REQ-013 dec_op  output  field_op_size x num_decoders (unpacked array)  op for slot, held until the next issue to that slot.
REQ-014 dec_busy  output  num_decoders  slot owns an unfinished op.
REQ-015 message_done  output  1  one-cycle pulse: all fields of message completed.
REQ-016 err_spurious  output  1  sticky: dec_done seen on a non-busy slot.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN, DONE; load_ready = 1 only in IDLE.
REQ-018 Load handshake = load_valid && load_ready at an edge; captures load_ops and count = min(load_count, max_message_size); clears issued and completed counters.
REQ-019 Handshake with count 0: next state DONE; otherwise next state ISSUE.
REQ-020 In ISSUE, at each edge at most one op issued: the op at index issued, to the first slot with dec_busy = 0 searching from rr_ptr upward, wrapping modulo num_decoders.
REQ-021 Issue at an edge: dec_issue[i] = 1 for the following cycle; dec_op[i] = op; dec_busy[i] = 1; issued += 1; rr_ptr = (i+1) mod num_decoders.
REQ-022 Slot eligibility uses registered dec_busy; a slot whose dec_done arrives this cycle is not eligible until the next edge.
REQ-023 ISSUE -> DRAIN at the edge that issues the last op (issued reaches count).
REQ-024 dec_done[i] with dec_busy[i] = 1 clears dec_busy[i] and increments completed; multiple done bits in one cycle add their popcount.
REQ-025 dec_done[i] with dec_busy[i] = 0 is ignored for counting and sets err_spurious.
REQ-026 DRAIN -> DONE at the edge where completed (including that cycle's done bits) reaches count; DONE lasts one cycle with message_done = 1, then IDLE.
REQ-027 Field ops issue strictly in index order; completions may arrive in any order.
REQ-028 abort at any state other than IDLE: next state IDLE, all dec_busy cleared, counters cleared, no message_done; dec_issue is 0 at that edge; abort has priority over issue and done.
REQ-029 abort in IDLE is a no-op; abort and load_valid in the same IDLE cycle: load is accepted.
REQ-030 dec_issue and message_done are registered outputs and never high for more than one consecutive cycle per event.

Reset
REQ-031 rstn low asynchronously forces IDLE, rr_ptr = 0, counters 0, dec_busy = 0, dec_issue = 0, dec_op = 0, message_done = 0, err_spurious = 0; load_ready = 1 while in IDLE.
REQ-032 Reset mid-message discards all state; first edge after deassertion behaves as IDLE.

Verification
REQ-033 Load count 3, ops 0xA,0xB,0xC; decoders never done -> dec_issue slots 0,1,2 on consecutive cycles, first pulse one cycle after the load edge; state DRAIN; dec_busy = 4'b0111.
REQ-034 Load count 6, four slots, done each slot 3 cycles after its issue -> ops 4 and 5 go to slots 0 and 1 after their done; message_done pulses once, one cycle after the sixth done.
REQ-035 Load count 0 -> message_done one cycle after the load edge; no dec_issue.
REQ-036 Load count 15 (> max 10) -> exactly 10 issues, then message_done.
REQ-037 Mid-DRAIN with two busy slots, assert abort -> next cycle IDLE, dec_busy = 0, load_ready = 1, no message_done; a new load proceeds normally with rr_ptr unchanged.
REQ-038 dec_done[3] pulsed while slot 3 idle -> err_spurious = 1 and held until rstn low; completed unchanged.
